mac_pe_stw_multi: RTL and testbench

Parametrised fixed-point systolic-array processing element with a multi-vector self-test-while-working (STW) engine. It computes the same weight-stationary and pass-through MAC as the current PE, but with configurable word and fraction width. A bank of `STW_DEPTH` test vectors is replayed through the live multiplier/adder, and a sticky fault flag switches the PE into accumulator bypass. It sits as one cell of the systolic array, with the array-level BIST/proxy controller driving the `stw_*` ports.

---
 rtl/mac_pe_pkg.sv | 16 +
 rtl/mac_pe_stw_multi_fxp_mul.sv | 22 ++
 rtl/mac_pe_stw_multi.sv | 197 +++++++++++++++++++
 tb/tb_mac_pe_stw_multi.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pe_pkg.sv
// Shared types for the self-testing systolic MAC processing element.
package mac_pe_pkg;

    // Self-test-while-working sequencer states
    typedef enum logic [1:0] {
        STW_IDLE = 2'd0,
        STW_RUN  = 2'd1,
        STW_HOLD = 2'd2
    } stw_state_e;

    // Index width for a bank of the given depth (at least one bit)
    function automatic int unsigned stw_idx_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/mac_pe_stw_multi_fxp_mul.sv
// Signed fixed-point multiply: full-width product, arithmetic shift by
// FRAC_BITS, truncate back to WORD_SIZE (wraps on overflow).
module fxp_mul #(
    parameter int unsigned WORD_SIZE = 16,
    parameter int unsigned FRAC_BITS = 8
) (
    input  logic [WORD_SIZE-1:0] a,
    input  logic [WORD_SIZE-1:0] b,
    output logic [WORD_SIZE-1:0] y
);

    localparam int unsigned PW = 2 * WORD_SIZE;

    logic signed [PW-1:0] prod;

    // Sign-extend both operands, multiply, rescale and truncate
    always_comb begin
        prod = PW'($signed(a)) * PW'($signed(b));
        y    = WORD_SIZE'(prod >>> FRAC_BITS);
    end

endmodule

// File: rtl/mac_pe_stw_multi.sv
// Weight-stationary / pass-through fixed-point MAC cell with a replayable
// bank of test vectors checked through the live multiplier and adder.
// A failed self-test latches fault_sticky, which bypasses the accumulator.
// Optional build macro MAC_FAULT_INJECT_EN adds a fault_inject[1:0] port
// that forces the multiplier result (bit0 = force, bit1 = forced value).
module mac_pe_stw_multi
    import mac_pe_pkg::*;
#(
    parameter int unsigned WORD_SIZE = 16,
    parameter int unsigned FRAC_BITS = 8,
    parameter int unsigned STW_DEPTH = 4,
    localparam int unsigned IW = (STW_DEPTH > 1) ? $clog2(STW_DEPTH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 op2_sel,
    input  logic                 out_sel,
    input  logic                 stat_bit,
    input  logic [WORD_SIZE-1:0] left_in,
    input  logic [WORD_SIZE-1:0] top_in,
    output logic [WORD_SIZE-1:0] right_out,
    output logic [WORD_SIZE-1:0] bottom_out,
    output logic [WORD_SIZE-1:0] stationary_out,
    input  logic                 stw_load_en,
    input  logic [IW-1:0]        stw_load_idx,
    input  logic [WORD_SIZE-1:0] stw_op1,
    input  logic [WORD_SIZE-1:0] stw_op2,
    input  logic [WORD_SIZE-1:0] stw_add,
    input  logic [WORD_SIZE-1:0] stw_expected,
    input  logic                 stw_start,
    output logic                 stw_busy,
    output logic                 stw_done,
    output logic                 stw_pass,
    output logic [IW-1:0]        stw_fail_idx,
    input  logic                 fault_clear,
`ifdef MAC_FAULT_INJECT_EN
    input  logic [1:0]           fault_inject,
`endif
    output logic                 fault_sticky
);

    typedef struct packed {
        logic [WORD_SIZE-1:0] op1;
        logic [WORD_SIZE-1:0] op2;
        logic [WORD_SIZE-1:0] add;
        logic [WORD_SIZE-1:0] expected;
    } stw_vec_t;

    stw_state_e           state;
    logic [IW-1:0]        idx;
    logic [IW-1:0]        first_fail;
    logic                 run_fail;
    stw_vec_t             vec_bank [STW_DEPTH];

    logic [WORD_SIZE-1:0] left_reg;
    logic [WORD_SIZE-1:0] top_reg;
    logic [WORD_SIZE-1:0] stat_reg;
    logic [WORD_SIZE-1:0] acc;

    logic                 busy_c;
    logic                 run_c;
    logic                 last_c;
    logic                 vec_miss_c;
    stw_vec_t             cur_vec_c;
    logic [WORD_SIZE-1:0] mul_a_c;
    logic [WORD_SIZE-1:0] mul_b_c;
    logic [WORD_SIZE-1:0] add_b_c;
    logic [WORD_SIZE-1:0] mul_raw_c;
    logic [WORD_SIZE-1:0] mul_res_c;
    logic [WORD_SIZE-1:0] sum_c;

    assign busy_c = (state != STW_IDLE);
    assign run_c  = (state == STW_RUN);
    assign last_c = (idx == IW'(STW_DEPTH - 1));

    // Operand steering: test vector during RUN, live MAC operands otherwise
    always_comb begin
        cur_vec_c = vec_bank[idx];
        mul_a_c   = left_reg;
        mul_b_c   = stat_bit ? stat_reg : top_reg;
        add_b_c   = stat_bit ? top_reg : acc;
        if (run_c) begin
            mul_a_c = cur_vec_c.op1;
            mul_b_c = cur_vec_c.op2;
            add_b_c = cur_vec_c.add;
        end
    end

    fxp_mul #(
        .WORD_SIZE (WORD_SIZE),
        .FRAC_BITS (FRAC_BITS)
    ) u_mul (
        .a (mul_a_c),
        .b (mul_b_c),
        .y (mul_raw_c)
    );

`ifdef MAC_FAULT_INJECT_EN
    assign mul_res_c = fault_inject[0] ? {WORD_SIZE{fault_inject[1]}} : mul_raw_c;
`else
    assign mul_res_c = mul_raw_c;
`endif

    assign sum_c      = mul_res_c + add_b_c;
    assign vec_miss_c = run_c && (sum_c != cur_vec_c.expected);

    assign right_out      = left_reg;
    assign bottom_out     = out_sel ? acc : top_reg;
    assign stationary_out = stat_reg;
    assign stw_busy       = busy_c;
    assign stw_done       = (state == STW_HOLD);

    // Systolic datapath registers; frozen by stall and while self-testing
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            left_reg <= '0;
            top_reg  <= '0;
            stat_reg <= '0;
            acc      <= '0;
        end else begin
            if (!stall && !busy_c) begin
                left_reg <= left_in;
                top_reg  <= top_in;
                acc      <= fault_sticky ? top_reg : sum_c;
            end
            if (op2_sel && !stall) begin
                stat_reg <= top_in;
            end
        end
    end

    // Test vector bank, writable only while idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STW_DEPTH; i++) begin
                vec_bank[i] <= '0;
            end
        end else if (stw_load_en && !stall && !busy_c &&
                     (32'(stw_load_idx) < STW_DEPTH)) begin
            vec_bank[stw_load_idx] <= '{op1:      stw_op1,
                                        op2:      stw_op2,
                                        add:      stw_add,
                                        expected: stw_expected};
        end
    end

    // Self-test sequencer with result and sticky fault registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= STW_IDLE;
            idx          <= '0;
            first_fail   <= '0;
            run_fail     <= 1'b0;
            stw_pass     <= 1'b1;
            stw_fail_idx <= '0;
            fault_sticky <= 1'b0;
        end else if (!stall) begin
            unique case (state)
                STW_IDLE: begin
                    if (fault_clear) begin
                        fault_sticky <= 1'b0;
                    end
                    if (stw_start) begin
                        state      <= STW_RUN;
                        idx        <= '0;
                        first_fail <= '0;
                        run_fail   <= 1'b0;
                    end
                end
                STW_RUN: begin
                    if (vec_miss_c && !run_fail) begin
                        run_fail   <= 1'b1;
                        first_fail <= idx;
                    end
                    if (last_c) begin
                        state        <= STW_HOLD;
                        stw_pass     <= !(run_fail || vec_miss_c);
                        stw_fail_idx <= run_fail ? first_fail : (vec_miss_c ? idx : '0);
                        if (run_fail || vec_miss_c) begin
                            fault_sticky <= 1'b1;
                        end
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                STW_HOLD: begin
                    state <= STW_IDLE;
                end
                default: begin
                    state <= STW_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_pe_stw_multi.sv
// Randomized, model-checked bench for mac_pe_stw_multi (16/8/4 configuration).
module tb_mac_pe_stw_multi;

    localparam int unsigned W  = 16;
    localparam int unsigned F  = 8;
    localparam int unsigned D  = 4;
    localparam int unsigned IW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          stall, op2_sel, out_sel, stat_bit;
    logic [W-1:0]  left_in, top_in;
    logic [W-1:0]  right_out, bottom_out, stationary_out;
    logic          stw_load_en;
    logic [IW-1:0] stw_load_idx;
    logic [W-1:0]  stw_op1, stw_op2, stw_add, stw_expected;
    logic          stw_start, stw_busy, stw_done, stw_pass;
    logic [IW-1:0] stw_fail_idx;
    logic          fault_clear, fault_sticky;
    logic [1:0]    fi = 2'b00;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mac_pe_stw_multi #(
        .WORD_SIZE (W),
        .FRAC_BITS (F),
        .STW_DEPTH (D)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .op2_sel        (op2_sel),
        .out_sel        (out_sel),
        .stat_bit       (stat_bit),
        .left_in        (left_in),
        .top_in         (top_in),
        .right_out      (right_out),
        .bottom_out     (bottom_out),
        .stationary_out (stationary_out),
        .stw_load_en    (stw_load_en),
        .stw_load_idx   (stw_load_idx),
        .stw_op1        (stw_op1),
        .stw_op2        (stw_op2),
        .stw_add        (stw_add),
        .stw_expected   (stw_expected),
        .stw_start      (stw_start),
        .stw_busy       (stw_busy),
        .stw_done       (stw_done),
        .stw_pass       (stw_pass),
        .stw_fail_idx   (stw_fail_idx),
        .fault_clear    (fault_clear),
`ifdef MAC_FAULT_INJECT_EN
        .fault_inject   (fi),
`endif
        .fault_sticky   (fault_sticky)
    );

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Fixed-point multiply from first principles (64-bit integer arithmetic)
    function automatic logic [W-1:0] m_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [1:0] inj);
        longint p;
        if (inj[0]) return {W{inj[1]}};
        p = longint'($signed(a)) * longint'($signed(b));
        p = p >>> F;
        return W'(p);
    endfunction

    // ---------------- behavioural model ----------------
    logic [W-1:0]  m_left, m_top, m_stat, m_acc, m_nacc, m_sum;
    logic [W-1:0]  m_op1 [D];
    logic [W-1:0]  m_op2 [D];
    logic [W-1:0]  m_add [D];
    logic [W-1:0]  m_exp [D];
    int            m_rem;      // busy cycles left (0 = idle, 1 = done cycle)
    bit            m_pass, m_fault, r_pass;
    logic [IW-1:0] m_fidx, r_fidx;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left = '0; m_top = '0; m_stat = '0; m_acc = '0;
            for (int i = 0; i < D; i++) begin
                m_op1[i] = '0; m_op2[i] = '0; m_add[i] = '0; m_exp[i] = '0;
            end
            m_rem = 0; m_pass = 1'b1; m_fault = 1'b0; m_fidx = '0;
            r_pass = 1'b1; r_fidx = '0;
        end else if (!stall) begin
            if (m_rem == 0) begin
                if (m_fault) m_nacc = m_top;
                else m_nacc = m_mul(m_left, stat_bit ? m_stat : m_top, fi) + (stat_bit ? m_top : m_acc);
                m_acc  = m_nacc;
                m_left = left_in;
                m_top  = top_in;
                if (stw_load_en && int'(stw_load_idx) < D) begin
                    m_op1[stw_load_idx] = stw_op1;
                    m_op2[stw_load_idx] = stw_op2;
                    m_add[stw_load_idx] = stw_add;
                    m_exp[stw_load_idx] = stw_expected;
                end
                if (fault_clear) m_fault = 1'b0;
                if (stw_start) begin
                    m_rem  = D + 1;
                    r_pass = 1'b1;
                    r_fidx = '0;
                    for (int i = 0; i < D; i++) begin
                        m_sum = m_mul(m_op1[i], m_op2[i], fi) + m_add[i];
                        if (r_pass && m_sum != m_exp[i]) begin
                            r_pass = 1'b0;
                            r_fidx = IW'(i);
                        end
                    end
                end
            end else begin
                m_rem--;
                if (m_rem == 1) begin
                    m_pass = r_pass;
                    m_fidx = r_fidx;
                    if (!r_pass) m_fault = 1'b1;
                end
            end
            if (op2_sel) m_stat = top_in;
        end
    end

    // Single compare process: every cycle outside reset
    always @(negedge clk) begin
        if (!rst) begin
            cmp("right_out",      32'(right_out),      32'(m_left));
            cmp("bottom_out",     32'(bottom_out),     32'(out_sel ? m_acc : m_top));
            cmp("stationary_out", 32'(stationary_out), 32'(m_stat));
            cmp("stw_busy",       32'(stw_busy),       32'(m_rem > 0));
            cmp("stw_done",       32'(stw_done),       32'(m_rem == 1));
            cmp("stw_pass",       32'(stw_pass),       32'(m_pass));
            cmp("fault_sticky",   32'(fault_sticky),   32'(m_fault));
            if (!m_pass) cmp("stw_fail_idx", 32'(stw_fail_idx), 32'(m_fidx));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic load_vec(input int i, input logic [W-1:0] o1, input logic [W-1:0] o2,
                            input logic [W-1:0] ad, input logic [W-1:0] ex);
        stw_load_idx = IW'(i);
        stw_op1 = o1; stw_op2 = o2; stw_add = ad; stw_expected = ex;
        stw_load_en = 1'b1;
        step();
        stw_load_en = 1'b0;
    endtask

    // Run one self-test; issues start/load while busy, optional 3-cycle stall
    task automatic run_stw(input bit with_stall, output int nbusy, output int ndone);
        int k;
        nbusy = 0; ndone = 0; k = 0;
        out_sel = 1'b0;
        left_in = 16'h0A5A; top_in = 16'h05A5;
        stw_start = 1'b1;
        step();
        stw_start = 1'b0;
        while (stw_busy && k < 40) begin
            nbusy++;
            if (stw_done) ndone++;
            left_in      = W'($urandom);
            top_in       = W'($urandom);
            stw_start    = (nbusy == 1);
            stw_load_en  = (nbusy == 1);
            stw_load_idx = '0;
            stw_expected = 16'hDEAD;
            stall        = with_stall && nbusy >= 2 && nbusy < 5;
            step();
            k++;
        end
        stall = 1'b0; stw_start = 1'b0; stw_load_en = 1'b0;
        if (k >= 40) begin
            errors++; checks++;
            $display("FAIL stw_timeout: busy still %0b after %0d cycles", stw_busy, k);
        end
        cmp("freeze_right",  32'(right_out),  32'h0A5A);
        cmp("freeze_bottom", 32'(bottom_out), 32'h05A5);
    endtask

    logic [W-1:0] o1, o2, ad;
    int nb, nd;

    initial begin
        stall = 0; op2_sel = 0; out_sel = 0; stat_bit = 0;
        left_in = '0; top_in = '0;
        stw_load_en = 0; stw_load_idx = '0;
        stw_op1 = '0; stw_op2 = '0; stw_add = '0; stw_expected = '0;
        stw_start = 0; fault_clear = 0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        cmp("rst_right",  32'(right_out),      32'h0);
        cmp("rst_bottom", 32'(bottom_out),     32'h0);
        cmp("rst_stat",   32'(stationary_out), 32'h0);
        cmp("rst_busy",   32'(stw_busy),       32'h0);
        cmp("rst_pass",   32'(stw_pass),       32'h1);
        cmp("rst_fault",  32'(fault_sticky),   32'h0);

        // Weight-stationary MAC: 0x0180 * 0x0200 (1.5 * 2.0) + 0x0100 = 0x0400
        op2_sel = 1; top_in = 16'h0200;
        step();
        op2_sel = 0; stat_bit = 1; left_in = 16'h0180; top_in = 16'h0100; out_sel = 1;
        step();
        step();
        cmp("mac_bottom", 32'(bottom_out), 32'h0400);
        cmp("model_mac",  32'(m_acc),      32'h0400);
        cmp("model_mul",  32'(m_mul(16'h0200, 16'h0300, 2'b00) + 16'h0100), 32'h0700);
        cmp("model_neg",  32'(m_mul(16'hFF00, 16'h0200, 2'b00)), 32'hFE00);

        // Four correct vectors
        load_vec(0, 16'h0200, 16'h0300, 16'h0100, 16'h0700);
        for (int i = 1; i < D; i++) begin
            o1 = W'($urandom); o2 = W'($urandom); ad = W'($urandom);
            load_vec(i, o1, o2, ad, m_mul(o1, o2, 2'b00) + ad);
        end
        run_stw(1'b0, nb, nd);
        cmp("run_busy_len", 32'(nb), 32'd5);
        cmp("run_done_cnt", 32'(nd), 32'd1);
        cmp("run_pass",     32'(stw_pass), 32'h1);

        // Vector 2 wrong -> fail, fault, bypass, clear
        o1 = 16'h0100; o2 = 16'h0100; ad = 16'h0001;
        load_vec(2, o1, o2, ad, 16'h0102);
        run_stw(1'b0, nb, nd);
        cmp("fail_pass",   32'(stw_pass),     32'h0);
        cmp("fail_idx",    32'(stw_fail_idx), 32'h2);
        cmp("fail_fault",  32'(fault_sticky), 32'h1);
        cmp("model_fidx",  32'(m_fidx),       32'h2);
        top_in = 16'h1234; out_sel = 1; stat_bit = 0;
        step();
        step();
        cmp("bypass_acc", 32'(bottom_out), 32'h1234);
        fault_clear = 1;
        step();
        fault_clear = 0;
        cmp("fault_cleared", 32'(fault_sticky), 32'h0);
        load_vec(2, o1, o2, ad, 16'h0101);

        // Stall for 3 cycles inside the run
        run_stw(1'b1, nb, nd);
        cmp("stall_busy_len", 32'(nb), 32'd8);
        cmp("stall_pass",     32'(stw_pass), 32'h1);
        run_stw(1'b0, nb, nd);
        cmp("busy_load_ignored", 32'(stw_pass), 32'h1);

`ifdef MAC_FAULT_INJECT_EN
        fi = 2'b11;
        run_stw(1'b0, nb, nd);
        cmp("inject_pass", 32'(stw_pass),     32'h0);
        cmp("inject_idx",  32'(stw_fail_idx), 32'h0);
        fi = 2'b00;
        fault_clear = 1;
        step();
        fault_clear = 0;
`endif

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            stall     = ($urandom_range(7) == 0);
            op2_sel   = ($urandom_range(3) == 0);
            stat_bit  = 1'($urandom_range(1));
            out_sel   = 1'($urandom_range(1));
            left_in   = W'($urandom);
            top_in    = W'($urandom);
            stw_start = ($urandom_range(15) == 0);
            stw_load_en  = ($urandom_range(7) == 0);
            stw_load_idx = IW'($urandom);
            stw_op1 = W'($urandom); stw_op2 = W'($urandom); stw_add = W'($urandom);
            stw_expected = ($urandom_range(3) == 0) ? W'($urandom)
                                                    : m_mul(stw_op1, stw_op2, fi) + stw_add;
            fault_clear = ($urandom_range(15) == 0);
            step();
        end
        stall = 0; op2_sel = 0; stw_start = 0; stw_load_en = 0; fault_clear = 0;
        repeat (8) step();

        // Failing run to set fault, then reset in the middle of the next run
        load_vec(1, 16'h0100, 16'h0100, 16'h0000, 16'h7777);
        run_stw(1'b0, nb, nd);
        cmp("pre_rst_fault", 32'(fault_sticky), 32'h1);
        stw_start = 1;
        step();
        stw_start = 0;
        step();
        #1 rst = 1'b1;
        #1;
        cmp("midrst_busy",   32'(stw_busy),       32'h0);
        cmp("midrst_pass",   32'(stw_pass),       32'h1);
        cmp("midrst_fault",  32'(fault_sticky),   32'h0);
        cmp("midrst_right",  32'(right_out),      32'h0);
        cmp("midrst_bottom", 32'(bottom_out),     32'h0);
        cmp("midrst_stat",   32'(stationary_out), 32'h0);
        step();
        rst = 1'b0;
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

endmodule
